// File: rtl/conv_gemm_if.sv
// Shared-memory port of the GEMM stage: one combinational read port, one write port.
// Latency: read data is valid in the same cycle as its address; writes land at the posedge.
// Backpressure: none; the memory always accepts a read and a write every cycle.
interface conv_gemm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [ACC_WIDTH-1:0]  data_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic                  mem_wr_en;

  // Engine side: issues addresses and write data, consumes read data.
  modport master (
    input  data_rd,
    output addr_rd,
    output data_wr,
    output addr_wr,
    output mem_wr_en
  );

  // Memory side.
  modport slave (
    output data_rd,
    input  addr_rd,
    input  data_wr,
    input  addr_wr,
    input  mem_wr_en
  );
endinterface

// File: rtl/conv_gemm.sv
// Convolution as GEMM: per output pixel, load one im2col row, then dot it with every weight row.
// Latency: 1 + NPIX*(K + OUT_C*(K+1)) cycles from the start sample to done.
// Backpressure: none; one memory read per cycle, one write per (oc,p), start ignored while busy.
module conv_gemm #(
  parameter int IMG_C       = 1,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int FILTER_SIZE = 3,
  parameter int OUT_C       = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h4000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 'h6000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  conv_gemm_if.master   mem
);
  localparam int K    = FILTER_SIZE * FILTER_SIZE * IMG_C;
  localparam int NPIX = IMG_H * IMG_W;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int OW   = (OUT_C > 1) ? $clog2(OUT_C) : 1;
  localparam logic [ADDR_WIDTH-1:0] K_A    = ADDR_WIDTH'(K);
  localparam logic [ADDR_WIDTH-1:0] NPIX_A = ADDR_WIDTH'(NPIX);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WR, DONE} state_t;

  state_t                 state;
  logic [KW-1:0]          k;
  logic [PW-1:0]          p;
  logic [OW-1:0]          oc;
  logic [ACC_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]  rowbuf [K];

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]           acc_sum;
  logic                           last_k;

  // Signed product of the buffered pixel element and the weight arriving this cycle;
  // the cast sign-extends (or truncates) into the accumulator, which wraps freely.
  assign prod    = $signed(rowbuf[k]) * $signed(mem.data_rd);
  assign acc_sum = acc + ACC_WIDTH'(prod);
  assign last_k  = (k == KW'(K - 1));

  // Row buffer capture: one im2col element per LOAD cycle; no reset needed since
  // every entry is rewritten before it is used for each pixel.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      rowbuf[k] <= mem.data_rd;
    end
  end

  // Control FSM with registered memory-side outputs; addresses advance incrementally
  // inside a row and are recomputed from the counters at row boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      p             <= '0;
      oc            <= '0;
      k             <= '0;
      acc           <= '0;
      mem.addr_rd   <= IM2COL_BASE;
      mem.addr_wr   <= OUTPUT_BASE;
      mem.data_wr   <= '0;
      mem.mem_wr_en <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            p           <= '0;
            k           <= '0;
            done        <= 1'b0;
            mem.addr_rd <= IM2COL_BASE;
          end
        end
        LOAD: begin
          if (last_k) begin
            state       <= MAC;
            oc          <= '0;
            k           <= '0;
            acc         <= '0;
            mem.addr_rd <= WEIGHT_BASE;
          end else begin
            k           <= k + 1'b1;
            mem.addr_rd <= mem.addr_rd + 1'b1;
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (last_k) begin
            state         <= WR;
            mem.mem_wr_en <= 1'b1;
            mem.data_wr   <= acc_sum;
            mem.addr_wr   <= OUTPUT_BASE + ADDR_WIDTH'(oc) * NPIX_A + ADDR_WIDTH'(p);
          end else begin
            k           <= k + 1'b1;
            mem.addr_rd <= mem.addr_rd + 1'b1;
          end
        end
        WR: begin
          mem.mem_wr_en <= 1'b0;
          k             <= '0;
          acc           <= '0;
          if (oc != OW'(OUT_C - 1)) begin
            state       <= MAC;
            oc          <= oc + 1'b1;
            mem.addr_rd <= WEIGHT_BASE + ADDR_WIDTH'(oc) * K_A + K_A;
          end else if (p != PW'(NPIX - 1)) begin
            state       <= LOAD;
            p           <= p + 1'b1;
            mem.addr_rd <= IM2COL_BASE + ADDR_WIDTH'(p) * K_A + K_A;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_gemm.sv
// Directed bench for conv_gemm: default instance on a modelled memory plus a 16-bit accumulator instance.
// Latency: checks start-to-done cycle count, write count, and every output word.
// Backpressure: none; memory answers reads combinationally and accepts writes every cycle.
module tb_conv_gemm;
  localparam int K    = 9;
  localparam int NPIX = 64;
  localparam int NOUT = 128;
  localparam int LAT  = 1857;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start16;
  logic done, done16;

  conv_gemm_if m0 ();
  conv_gemm_if #(.ACC_WIDTH(16)) m1 ();

  conv_gemm u_dut (.clk(clk), .rst_n(rst_n), .start(start), .done(done), .mem(m0.master));
  conv_gemm #(.ACC_WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .start(start16), .done(done16), .mem(m1.master));

  always #5 clk = ~clk;

  logic [7:0]  im_mem  [NPIX*K];
  logic [7:0]  w_mem   [2*K];
  logic [31:0] out_mem [NOUT];
  logic [31:0] exp_mem [NOUT];
  logic [15:0] out16   [NOUT];
  int wr_count, bad_wr, wr16, bad16;
  int errors = 0;
  int checks = 0;

  // Memory model for the default instance: combinational read, write at posedge.
  always_comb begin
    m0.data_rd = '0;
    if (m0.addr_rd >= 32'h2000 && m0.addr_rd < 32'h2000 + NPIX*K)
      m0.data_rd = im_mem[m0.addr_rd - 32'h2000];
    else if (m0.addr_rd >= 32'h4000 && m0.addr_rd < 32'h4000 + 2*K)
      m0.data_rd = w_mem[m0.addr_rd - 32'h4000];
  end

  always @(posedge clk) begin
    if (m0.mem_wr_en === 1'b1) begin
      if (m0.addr_wr >= 32'h6000 && m0.addr_wr < 32'h6000 + NOUT)
        out_mem[m0.addr_wr - 32'h6000] <= m0.data_wr;
      else
        bad_wr++;
      wr_count++;
    end
  end

  // Narrow-accumulator instance sees 127 at every address.
  assign m1.data_rd = 8'd127;

  always @(posedge clk) begin
    if (m1.mem_wr_en === 1'b1) begin
      if (m1.addr_wr >= 32'h6000 && m1.addr_wr < 32'h6000 + NOUT)
        out16[m1.addr_wr - 32'h6000] <= m1.data_wr;
      else
        bad16++;
      wr16++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_outputs();
    for (int i = 0; i < NOUT; i++) out_mem[i] = 32'hDEADBEEF;
    wr_count = 0;
    bad_wr   = 0;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NOUT; i++)
      chk($sformatf("%s[%0d]", tag, i), out_mem[i], exp_mem[i]);
    chk({tag, "_wr_count"}, wr_count, NOUT);
    chk({tag, "_bad_addr"}, bad_wr, 0);
  endtask

  // One pass: start sampled at the first edge (c=1); optionally re-pulse start later.
  task automatic run_pass(input int pulse_at, output int lat, output logic done1);
    lat   = -1;
    done1 = 1'bx;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk);
      #1;
      start = (c == pulse_at);
      if (c == 1) done1 = done;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  int   lat;
  logic d1;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    start16 = 1'b0;
    wr16    = 0;
    bad16   = 0;
    clear_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_rd", m0.addr_rd, 32'h2000);
    chk("rst_addr_wr", m0.addr_wr, 32'h6000);
    chk("rst_data_wr", m0.data_wr, 0);
    chk("rst_wr_en", m0.mem_wr_en, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start_done", done, 0);

    // All ones: every dot product is 9; start pulsed mid-MAC must be ignored.
    for (int i = 0; i < NPIX*K; i++) im_mem[i] = 8'h01;
    for (int i = 0; i < 2*K; i++) w_mem[i] = 8'h01;
    for (int i = 0; i < NOUT; i++) exp_mem[i] = 32'd9;
    clear_outputs();
    run_pass(12, lat, d1);
    chk("t1_latency", lat, LAT);
    check_outputs("t1_out");
    repeat (3) @(negedge clk);
    chk("done_holds", done, 1);
    chk("done_wr_en_low", m0.mem_wr_en, 0);

    // Restart from DONE: done drops in the first LOAD cycle, identical pass follows.
    clear_outputs();
    run_pass(0, lat, d1);
    chk("t6_done_fall", d1, 0);
    chk("t6_latency", lat, LAT);
    check_outputs("t6_out");

    // Negative pixels: oc0 = 9*(-1*2) = -18, oc1 = 9*(-1*-3) = 27.
    for (int i = 0; i < NPIX*K; i++) im_mem[i] = 8'hFF;
    for (int i = 0; i < K; i++) begin
      w_mem[i]     = 8'h02;
      w_mem[K + i] = 8'hFD;
    end
    for (int i = 0; i < NPIX; i++) begin
      exp_mem[i]        = 32'hFFFFFFEE;
      exp_mem[NPIX + i] = 32'd27;
    end
    clear_outputs();
    run_pass(0, lat, d1);
    chk("t2_latency", lat, LAT);
    check_outputs("t2_out");

    // One-hot weights select single im2col columns (k=4 for oc0, k=0 for oc1).
    for (int i = 0; i < NPIX*K; i++) im_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 2*K; i++) w_mem[i] = 8'h00;
    w_mem[4] = 8'h01;
    w_mem[K] = 8'h01;
    for (int i = 0; i < NPIX; i++) begin
      exp_mem[i]        = {{24{im_mem[i*K+4][7]}}, im_mem[i*K+4]};
      exp_mem[NPIX + i] = {{24{im_mem[i*K][7]}}, im_mem[i*K]};
    end
    clear_outputs();
    run_pass(0, lat, d1);
    chk("t3_latency", lat, LAT);
    check_outputs("t3_out");

    // Reset during MAC of p=10 (MAC spans edges 300..308); sampled at edge 305.
    for (int i = 0; i < NPIX*K; i++) im_mem[i] = 8'h01;
    for (int i = 0; i < 2*K; i++) w_mem[i] = 8'h01;
    for (int i = 0; i < NOUT; i++) exp_mem[i] = 32'd9;
    clear_outputs();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 305; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 304) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    chk("t5_rst_addr_rd", m0.addr_rd, 32'h2000);
    chk("t5_rst_addr_wr", m0.addr_wr, 32'h6000);
    chk("t5_rst_data_wr", m0.data_wr, 0);
    chk("t5_rst_wr_en", m0.mem_wr_en, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_writes_before_rst", wr_count, 20);
    repeat (30) @(negedge clk);
    chk("t5_no_writes_after_rst", wr_count, 20);
    chk("t5_idle_done", done, 0);
    clear_outputs();
    run_pass(0, lat, d1);
    chk("t5_rerun_latency", lat, LAT);
    check_outputs("t5_out");

    // 16-bit accumulator: 9*127*127 = 145161 wraps to 16'h3709.
    @(negedge clk);
    start16 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk);
      #1;
      start16 = 1'b0;
      if (done16 === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("t4_latency", lat, LAT);
    chk("t4_wr_count", wr16, NOUT);
    chk("t4_bad_addr", bad16, 0);
    for (int i = 0; i < NOUT; i++)
      chk($sformatf("t4_out[%0d]", i), out16[i], 16'h3709);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_gemm.md
Name: conv_gemm

Overview:
- Downstream consumer of the im2col stage.
- Once started, it reads the im2col matrix (one row per output pixel, K = FILTER_SIZE*FILTER_SIZE*IMG_C columns) and the weight matrix (OUT_C rows of K) from shared memory.
- It computes signed multiply-accumulate dot products and writes the convolution output to memory in channel-major order.
- It uses a single read port and a single write port, in the same memory style as the im2col stage. The im2col `done` drives `start`.

Parameters:
- IMG_C, 1, input channels
- IMG_W, 8, image width (output width, same padding)
- IMG_H, 8, image height
- FILTER_SIZE, 3, square kernel size
- OUT_C, 2, output channels
- DATA_WIDTH, 8, signed element width of im2col and weights
- ACC_WIDTH, 32, accumulator and output word width
- ADDR_WIDTH, 32, address width
- IM2COL_BASE, 16'h2000, im2col base; element (p,k) is at IM2COL_BASE+p*K+k
- WEIGHT_BASE, 16'h4000, weights; element (oc,k) is at WEIGHT_BASE+oc*K+k
- OUTPUT_BASE, 16'h6000, outputs; (oc,p) is at OUTPUT_BASE+oc*IMG_H*IMG_W+p

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  level/pulse; sampled only in IDLE or DONE
- data_rd  in  DATA_WIDTH  memory read data; combinational mem[addr_rd] in the same cycle
- addr_rd  out  ADDR_WIDTH  read address
- data_wr  out  ACC_WIDTH  write data
- addr_wr  out  ADDR_WIDTH  write address
- mem_wr_en  out  1  memory writes data_wr to addr_wr at the posedge when high
- done  out  1  high when all outputs have been written

Behaviour:
- **Reset** (rst_n low at posedge): state=IDLE; counters p, oc, k = 0; acc=0.
  - addr_rd=IM2COL_BASE, addr_wr=OUTPUT_BASE, data_wr=0, mem_wr_en=0, done=0.
  - Reset mid-operation aborts immediately. No further writes occur until the next start.
- **Memory model:** data_rd seen at a posedge corresponds to the addr_rd driven during the cycle just ended. Each read therefore costs exactly one cycle.
- **IDLE:** on start=1, go to LOAD with p=0, k=0. addr_rd must equal IM2COL_BASE during the first LOAD cycle.
- **LOAD** (K cycles):
  - Each cycle: rowbuf[k] <= data_rd, with addr_rd = IM2COL_BASE+p*K+k.
  - At k==K-1: go to MAC with oc=0, k=0, acc=0.
- **MAC** (K cycles):
  - addr_rd = WEIGHT_BASE+oc*K+k.
  - acc <= acc + sext(rowbuf[k]) * sext(data_rd), with a signed DATA_WIDTH x DATA_WIDTH product.
  - Arithmetic is modulo 2^ACC_WIDTH; wrap, no saturation.
  - At k==K-1: go to WR.
- **WR** (1 cycle): mem_wr_en=1, addr_wr = OUTPUT_BASE+oc*IMG_H*IMG_W+p, data_wr = final acc (including the last product).
  - If oc<OUT_C-1: oc++, acc=0, go to MAC.
  - Else if p<IMG_H*IMG_W-1: p++, go to LOAD.
  - Else: go to DONE.
- **DONE:** done=1, mem_wr_en=0.
  - Stays in DONE until start=1, then goes to LOAD (p=0). done falls in the first LOAD cycle.
- **Control rules:**
  - start is ignored in LOAD, MAC and WR.
  - mem_wr_en is high only in WR, and exactly once per (oc,p).
- **Latency from start sample to done=1:** 1 + IMG_H*IMG_W*(K + OUT_C*(K+1)) cycles. With defaults (K=9) this is 1 + 64*29 = 1857.
- **Address arithmetic:**
  - Computed in ADDR_WIDTH.
  - Counters are wide enough for IMG_H*IMG_W and K.
  - Incremental address update is permitted; only the values above matter.
- **rowbuf:** K x DATA_WIDTH register array, rewritten for every p.

Test Plan:
- Defaults; im2col all 8'h01, weights all 8'h01; pulse start → 128 writes, each data_wr=9, to addresses 0x6000..0x607F; done rises exactly 1857 cycles after start sampled.
- im2col all 8'hFF (−1); weights oc0=2, oc1=8'hFD (−3) → oc0 outputs 32'hFFFFFFEE (−18); oc1 outputs 27.
- Weights oc0 = one-hot at k=4 (value 1), oc1 = one-hot at k=0 (value 1); random im2col → mem[0x6000+p]=sext(im2col[p][4]) and mem[0x6040+p]=sext(im2col[p][0]) for all p.
- Override ACC_WIDTH=16; im2col all 127, weights all 127 → every output = 145161 mod 65536 = 16'h3709 (wrap, no saturation).
- rst_n low for 1 cycle during MAC of p=10 → next cycle all outputs are at reset values, no mem_wr_en until start; rerun completes with correct results.
- start pulsed during MAC → ignored, and the write count stays 128; start in DONE → done falls next cycle and a second identical 128-write pass follows.
